// File: rtl/mon_dispatch_arb_pkg.sv
// Shared constants and helpers for the monitor dispatch arbiter and its lanes.
package mon_dispatch_arb_pkg;

  localparam int EVT_W_DEFAULT = 32;

  // Lane-ID width; kept at least 1 so a two-lane build still has a real index bit.
  function automatic int lane_w(input int n_mon);
    return (n_mon <= 2) ? 1 : $clog2(n_mon);
  endfunction

endpackage

// File: rtl/mon_dispatch_arb_order_fifo.sv
// Small circular FIFO of lane IDs that remembers dispatch order.
// A push and a pop in the same cycle leave the count unchanged.
module mon_order_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         empty,
  output logic         full
);

  localparam int PTR_W = (DEPTH <= 2) ? 1 : $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mon_dispatch_arb.sv
// Round-robin dispatcher of DUT transactions to sub_mon lanes, with in-order event return.
// Optional MON_ARB_STATS_EN adds saturating accept/stall counters.
module mon_dispatch_arb
  import mon_dispatch_arb_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int EVT_W = EVT_W_DEFAULT,
  parameter int N_MON = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_txn_valid,
  output logic                   o_txn_ready,
  input  logic [WIDTH-1:0]       i_dut_ia,
  input  logic [WIDTH-1:0]       i_dut_ib,
  input  logic [WIDTH-1:0]       i_dut_os,
  output logic [N_MON-1:0]       o_mon_valid,
  output logic [WIDTH-1:0]       o_mon_a,
  output logic [WIDTH-1:0]       o_mon_b,
  output logic [WIDTH-1:0]       o_mon_o,
  input  logic [N_MON-1:0]       i_mon_evt_valid,
  input  logic [N_MON*EVT_W-1:0] i_mon_evt,
  output logic                   o_event_valid,
  output logic [EVT_W-1:0]       o_event,
  output logic                   o_err
`ifdef MON_ARB_STATS_EN
  ,
  output logic [31:0]            o_stat_txn,
  output logic [31:0]            o_stat_stall
`endif
);

  localparam int LANE_W = lane_w(N_MON);

  logic [N_MON-1:0]  lane_busy;
  logic [N_MON-1:0]  hold_valid;
  logic [EVT_W-1:0]  hold [N_MON];
  logic [LANE_W-1:0] rr_ptr;
  logic [LANE_W-1:0] grant;
  logic              grant_found;
  logic              accept;
  logic [LANE_W-1:0] head;
  logic              fifo_empty;
  logic              fifo_full;
  logic              pop;

  assign o_txn_ready = |(~lane_busy);
  assign accept      = i_txn_valid & o_txn_ready;
  assign pop         = ~fifo_empty & hold_valid[head];

  always_comb begin
    int idx;
    grant_found = 1'b0;
    grant       = '0;
    idx         = 0;
    for (int i = 0; i < N_MON; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= N_MON) idx = idx - N_MON;
      if (!grant_found && !lane_busy[idx]) begin
        grant_found = 1'b1;
        grant       = LANE_W'(idx);
      end
    end
  end

  mon_order_fifo #(
    .DEPTH (N_MON),
    .W     (LANE_W)
  ) u_order_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (accept & grant_found & ~fifo_full),
    .push_data (grant),
    .pop       (pop),
    .head      (head),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lane_busy     <= '0;
      hold_valid    <= '0;
      rr_ptr        <= '0;
      o_mon_valid   <= '0;
      o_mon_a       <= '0;
      o_mon_b       <= '0;
      o_mon_o       <= '0;
      o_event_valid <= 1'b0;
      o_event       <= '0;
      o_err         <= 1'b0;
      for (int l = 0; l < N_MON; l++) hold[l] <= '0;
    end else begin
      o_mon_valid   <= '0;
      o_event_valid <= 1'b0;

      if (accept) begin
        lane_busy[grant]   <= 1'b1;
        rr_ptr             <= (grant == LANE_W'(N_MON - 1)) ? '0 : grant + LANE_W'(1);
        o_mon_valid[grant] <= 1'b1;
        o_mon_a            <= i_dut_ia;
        o_mon_b            <= i_dut_ib;
        o_mon_o            <= i_dut_os;
      end

      // Events on idle lanes or lanes already holding one are dropped and flagged.
      for (int l = 0; l < N_MON; l++) begin
        if (i_mon_evt_valid[l]) begin
          if (lane_busy[l] && !hold_valid[l]) begin
            hold_valid[l] <= 1'b1;
            hold[l]       <= i_mon_evt[l*EVT_W +: EVT_W];
          end else begin
            o_err <= 1'b1;
          end
        end
      end

      if (pop) begin
        o_event          <= hold[head];
        o_event_valid    <= 1'b1;
        hold_valid[head] <= 1'b0;
        lane_busy[head]  <= 1'b0;
      end
    end
  end

`ifdef MON_ARB_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_stat_txn   <= '0;
      o_stat_stall <= '0;
    end else begin
      if (accept && (o_stat_txn != '1)) o_stat_txn <= o_stat_txn + 32'd1;
      if (i_txn_valid && !o_txn_ready && (o_stat_stall != '1)) o_stat_stall <= o_stat_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mon_dispatch_arb.sv
// Directed bench for mon_dispatch_arb with N_MON=2, WIDTH=EVT_W=32.
// Stats checks are compiled in only when MON_ARB_STATS_EN is defined.
module tb_mon_dispatch_arb;

  localparam int WIDTH = 32;
  localparam int EVT_W = 32;
  localparam int N_MON = 2;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   i_txn_valid;
  logic                   o_txn_ready;
  logic [WIDTH-1:0]       i_dut_ia, i_dut_ib, i_dut_os;
  logic [N_MON-1:0]       o_mon_valid;
  logic [WIDTH-1:0]       o_mon_a, o_mon_b, o_mon_o;
  logic [N_MON-1:0]       i_mon_evt_valid;
  logic [N_MON*EVT_W-1:0] i_mon_evt;
  logic                   o_event_valid;
  logic [EVT_W-1:0]       o_event;
  logic                   o_err;
`ifdef MON_ARB_STATS_EN
  logic [31:0]            o_stat_txn, o_stat_stall;
`endif

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  mon_dispatch_arb #(
    .WIDTH (WIDTH),
    .EVT_W (EVT_W),
    .N_MON (N_MON)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .i_txn_valid     (i_txn_valid),
    .o_txn_ready     (o_txn_ready),
    .i_dut_ia        (i_dut_ia),
    .i_dut_ib        (i_dut_ib),
    .i_dut_os        (i_dut_os),
    .o_mon_valid     (o_mon_valid),
    .o_mon_a         (o_mon_a),
    .o_mon_b         (o_mon_b),
    .o_mon_o         (o_mon_o),
    .i_mon_evt_valid (i_mon_evt_valid),
    .i_mon_evt       (i_mon_evt),
    .o_event_valid   (o_event_valid),
    .o_event         (o_event),
    .o_err           (o_err)
`ifdef MON_ARB_STATS_EN
    ,
    .o_stat_txn      (o_stat_txn),
    .o_stat_stall    (o_stat_stall)
`endif
  );

  // Advance one cycle; drive and sample 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic txn(input logic [31:0] a, input logic [31:0] b, input logic [31:0] o);
    i_txn_valid = 1'b1;
    i_dut_ia    = a;
    i_dut_ib    = b;
    i_dut_os    = o;
  endtask

  task automatic evt(input int lane, input logic [31:0] data);
    i_mon_evt_valid       = '0;
    i_mon_evt_valid[lane] = 1'b1;
    i_mon_evt[lane*EVT_W +: EVT_W] = data;
  endtask

  logic [1:0]  lane_seq [5] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01};

  initial begin
    reset           = 1'b1;
    i_txn_valid     = 1'b0;
    i_dut_ia        = '0;
    i_dut_ib        = '0;
    i_dut_os        = '0;
    i_mon_evt_valid = '0;
    i_mon_evt       = '0;
    step(); step();
    reset = 1'b0;
    step();

    // 1. reset state
    chk("rst_ready",  o_txn_ready,   1'b1);
    chk("rst_monv",   o_mon_valid,   2'b00);
    chk("rst_evv",    o_event_valid, 1'b0);
    chk("rst_err",    o_err,         1'b0);
    chk("rst_mon_a",  o_mon_a,       32'd0);

    // 2. back-to-back A, B; C stalls
    txn(1, 2, 3);
    step();
    chk("a_monv", o_mon_valid, 2'b01);
    chk("a_a",    o_mon_a,     32'd1);
    chk("a_b",    o_mon_b,     32'd2);
    chk("a_o",    o_mon_o,     32'd3);
    txn(4, 5, 9);
    step();
    chk("b_monv", o_mon_valid, 2'b10);
    chk("b_a",    o_mon_a,     32'd4);
    chk("b_o",    o_mon_o,     32'd9);
    txn(7, 8, 15);
    chk("c_ready", o_txn_ready, 1'b0);
    step();
    i_txn_valid = 1'b0;
    chk("c_monv", o_mon_valid, 2'b00);
    chk("c_hold_a", o_mon_a,   32'd4);

    // 3. out-of-order completion: lane1 at t, lane0 at t+3
    evt(1, 32'hBBBB);               // cycle t
    step();
    i_mon_evt_valid = '0;           // t+1
    chk("ooo_t1_evv", o_event_valid, 1'b0);
    step();                         // t+2
    chk("ooo_t2_evv", o_event_valid, 1'b0);
    step();                         // t+3
    evt(0, 32'hAAAA);
    step();                         // t+4
    i_mon_evt_valid = '0;
    chk("ooo_t4_evv", o_event_valid, 1'b0);
    step();                         // t+5
    chk("ooo_t5_evv", o_event_valid, 1'b1);
    chk("ooo_t5_ev",  o_event,       32'hAAAA);
    step();                         // t+6
    chk("ooo_t6_evv",   o_event_valid, 1'b1);
    chk("ooo_t6_ev",    o_event,       32'hBBBB);
    chk("ooo_t6_ready", o_txn_ready,   1'b1);
    step();                         // t+7
    chk("ooo_t7_evv",  o_event_valid, 1'b0);
    chk("ooo_t7_hold", o_event,       32'hBBBB);
    chk("ooo_err",     o_err,         1'b0);

    // 4. five serial transactions alternate lanes 0,1,0,1,0
    for (int k = 0; k < 5; k++) begin
      txn(32'h10 + k, 0, 0);
      step();
      i_txn_valid = 1'b0;
      chk($sformatf("ser%0d_lane", k), o_mon_valid, lane_seq[k]);
      chk($sformatf("ser%0d_a", k),    o_mon_a,     32'h10 + k);
      evt((k % 2), 32'h100 + k);
      step();
      i_mon_evt_valid = '0;
      step();
      chk($sformatf("ser%0d_evv", k), o_event_valid, 1'b1);
      chk($sformatf("ser%0d_ev", k),  o_event,       32'h100 + k);
    end

    // 5. event on idle lane1 -> sticky error, no event
    step();
    evt(1, 32'h1234);
    step();
    i_mon_evt_valid = '0;
    chk("idle_err1", o_err,         1'b1);
    chk("idle_evv1", o_event_valid, 1'b0);
    step();
    chk("idle_err2", o_err,         1'b1);
    chk("idle_evv2", o_event_valid, 1'b0);
    chk("idle_ev",   o_event,       32'h104);
    step();
    chk("idle_err3", o_err,         1'b1);

    // 6. reset with two lanes outstanding, then D goes to lane0
    txn(32'h21, 0, 0);
    step();
    txn(32'h22, 0, 0);
    step();
    i_txn_valid = 1'b0;
    chk("pre_rst_ready", o_txn_ready, 1'b0);
    evt(0, 32'hDEAD);
    reset = 1'b1;
    step();
    i_mon_evt_valid = '0;
    reset = 1'b0;
    chk("mid_rst_err",   o_err,         1'b0);
    chk("mid_rst_ready", o_txn_ready,   1'b1);
    chk("mid_rst_evv",   o_event_valid, 1'b0);
    chk("mid_rst_ev",    o_event,       32'd0);
    txn(32'hD, 0, 0);
    step();                          // x+1
    chk("d_lane", o_mon_valid, 2'b01);
    chk("d_a",    o_mon_a,     32'hD);
    txn(32'hE, 0, 0);
    step();                          // x+2
    chk("e_lane",  o_mon_valid, 2'b10);
    chk("e_evv",   o_event_valid, 1'b0);
    txn(32'hF, 0, 0);
    chk("f_stall", o_txn_ready, 1'b0);
    step();                          // x+3
    step();                          // x+4
    i_txn_valid = 1'b0;
`ifdef MON_ARB_STATS_EN
    chk("stat_txn2",   o_stat_txn,   32'd2);
    chk("stat_stall2", o_stat_stall, 32'd2);
`endif
    evt(0, 32'h5A5A);
    step();                          // x+5
    i_mon_evt_valid = '0;
    chk("de_evv_early", o_event_valid, 1'b0);
    step();                          // x+6
    chk("d_evv", o_event_valid, 1'b1);
    chk("d_ev",  o_event,       32'h5A5A);
    txn(32'hF, 0, 0);
    step();                          // x+7
    i_txn_valid = 1'b0;
    chk("f_lane", o_mon_valid, 2'b01);
    chk("f_a",    o_mon_a,     32'hF);
`ifdef MON_ARB_STATS_EN
    chk("stat_txn3",   o_stat_txn,   32'd3);
    chk("stat_stall3", o_stat_stall, 32'd2);
`endif
    chk("end_err", o_err, 1'b0);
    step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
